grant_session_ctrl: RTL
=======================

Name: grant_session_ctrl

Overview:
- Sits directly downstream of the b03 four-requester arbiter and consumes its registered grant vector GRANT_O[3:0].
- Converts each grant into a bounded bus-ownership session: drives the owner select and a valid flag, then terminates the session on a DONE from the owner, on timeout, or on grant withdrawal.
- Pulses a per-requester RELEASE so the requester can drop its REQUEST.
- Keeps saturating per-requester session counters for fairness checks and flags illegal multi-hot grants.

Parameters:
HOLD_MAX, 8, maximum session length in cycles (legal range 2..255)
CNT_W, 8, width of each per-requester session counter

Ports:
CLOCK  in  1  single clock, rising edge
RESET_N  in  1  asynchronous, active-low reset
GRANT_O  in  4  grant vector from arbiter; legal values are zero or one-hot
DONE  in  4  per-requester end-of-session strobe; only DONE[owner] is used
CLR_STATS  in  1  synchronous clear of GRANT_CNT and ERR_MULTI
BUS_VALID  out  1  high while a session is ACTIVE
SEL  out  2  index of current owner (0..3), valid when BUS_VALID=1
RELEASE  out  4  one-cycle pulse to the owner at session end
TIMEOUT  out  1  one-cycle pulse, coincident with RELEASE, when a session ended by HOLD_MAX
ERR_MULTI  out  1  sticky; set when GRANT_O is multi-hot while sampled in IDLE
BUSY  out  1  high in any state other than IDLE
GRANT_CNT  out  4*CNT_W  packed saturating session counters; requester i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - state=IDLE, owner=0, hold counter=0.
  - BUS_VALID=0, SEL=0, RELEASE=0, TIMEOUT=0, ERR_MULTI=0, BUSY=0, GRANT_CNT=0.
  - Reset mid-session aborts the session silently, with no RELEASE pulse.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- State machine: IDLE, ACTIVE, REL, GAP.
- IDLE:
  - GRANT_O one-hot at edge N: owner<=index, hold<=0, go ACTIVE. BUS_VALID=1 and SEL=owner from cycle N+1.
  - GRANT_O multi-hot: ERR_MULTI<=1, stay IDLE.
  - GRANT_O zero: stay IDLE.
- ACTIVE: hold increments each cycle. Exit conditions, in priority order:
  1. GRANT_O[owner]=0 (abort) -> REL, no TIMEOUT.
  2. DONE[owner]=1 -> REL, no TIMEOUT.
  3. hold==HOLD_MAX-1 -> REL, set timeout flag.
  - DONE bits of non-owners are ignored.
  - Result: BUS_VALID is high for at most HOLD_MAX cycles.
- REL (exactly one cycle):
  - RELEASE[owner]=1, TIMEOUT=flag, BUS_VALID=0.
  - GRANT_CNT[owner] increments, saturating at 2^CNT_W-1.
  - Then go GAP.
- GAP:
  - Stay while GRANT_O[owner]=1, so a stale grant is never re-latched.
  - Leave to IDLE once GRANT_O[owner]=0. There is no GAP time limit.
- CLR_STATS:
  - Zeroes all GRANT_CNT fields and ERR_MULTI at the next edge.
  - Wins over a same-cycle REL increment (counter ends at 0) and over a same-cycle ERR_MULTI set.
  - Does not affect the FSM.
- Simultaneous DONE[owner] and timeout in the same cycle: treated as DONE, TIMEOUT=0.
- Minimum turnaround: IDLE -> ACTIVE -> REL -> GAP -> IDLE is 4 cycles when the arbiter drops the grant immediately after RELEASE.

Test Plan:
- Reset: assert RESET_N=0 mid-ACTIVE with SEL=2 -> all outputs 0 asynchronously, with no RELEASE pulse. Release reset with GRANT_O=0 -> BUSY=0.
- Normal DONE session:
  - GRANT_O=4'b0100 at edge 0 -> BUS_VALID=1, SEL=2 from cycle 1.
  - DONE=4'b0100 in cycle 3 -> RELEASE=4'b0100, TIMEOUT=0 in cycle 4.
  - GRANT_CNT[2]=1.
  - Hold GRANT_O=0100 -> stays GAP; drop to 0 -> IDLE.
- Timeout (HOLD_MAX=8): GRANT_O=0001 held with DONE=0 -> BUS_VALID high exactly 8 cycles, then RELEASE=0001 with TIMEOUT=1 for one cycle.
- Priority and abort:
  - DONE[owner] coinciding with hold==7 -> TIMEOUT=0.
  - GRANT_O drops to 0 mid-session -> RELEASE pulse next cycle, TIMEOUT=0.
  - DONE=1000 while owner=1 -> ignored.
- Multi-hot grant: GRANT_O=0011 in IDLE -> ERR_MULTI=1 sticky, BUSY stays 0. CLR_STATS=1 -> ERR_MULTI=0.
- Saturation and clear (CNT_W=2): run 5 sessions on requester 3 -> GRANT_CNT[3]=3. CLR_STATS in the same cycle as REL -> GRANT_CNT[3]=0.

Source files
------------

// File: rtl/grant_session_ctrl.sv
// Grant-to-session controller downstream of the four-requester arbiter.
// Bounds each bus ownership, pulses RELEASE, keeps per-requester stats.
module grant_session_ctrl #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic [3:0]         GRANT_O,
  input  logic [3:0]         DONE,
  input  logic               CLR_STATS,
  output logic               BUS_VALID,
  output logic [1:0]         SEL,
  output logic [3:0]         RELEASE,
  output logic               TIMEOUT,
  output logic               ERR_MULTI,
  output logic               BUSY,
  output logic [4*CNT_W-1:0] GRANT_CNT
);

  localparam int HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_REL,
    S_GAP
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [1:0]                 r_owner;
  logic [HOLD_W-1:0]          r_hold;
  logic                       r_to;
  logic                       r_err;
  logic [3:0][CNT_W-1:0]      r_cnt;

  logic [1:0]                 w_gidx;
  logic                       w_multi;
  logic                       w_onehot;
  logic                       w_own_g;
  logic                       w_own_d;
  logic                       w_hold_end;
  logic                       w_start;

  assign w_multi    = (GRANT_O & (GRANT_O - 4'd1)) != 4'd0;
  assign w_onehot   = (GRANT_O != 4'd0) && !w_multi;
  assign w_own_g    = GRANT_O[r_owner];
  assign w_own_d    = DONE[r_owner];
  assign w_hold_end = r_hold == HOLD_LAST;
  assign w_start    = (r_state == S_IDLE) && w_onehot;

  always_comb begin
    w_gidx = 2'd0;
    case (1'b1)
      GRANT_O[0]: w_gidx = 2'd0;
      GRANT_O[1]: w_gidx = 2'd1;
      GRANT_O[2]: w_gidx = 2'd2;
      GRANT_O[3]: w_gidx = 2'd3;
      default:    w_gidx = 2'd0;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_onehot) w_next = S_ACTIVE;
      S_ACTIVE: begin
        if (!w_own_g || w_own_d || w_hold_end)
          w_next = S_REL;
      end
      S_REL:    w_next = S_GAP;
      S_GAP:    if (!w_own_g) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    BUS_VALID = r_state == S_ACTIVE;
    SEL       = r_owner;
    RELEASE   = 4'd0;
    TIMEOUT   = 1'b0;
    BUSY      = r_state != S_IDLE;
    if (r_state == S_REL) begin
      RELEASE[r_owner] = 1'b1;
      TIMEOUT          = r_to;
    end
  end

  // Timeout flag only when neither abort nor DONE claimed the exit.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_owner <= 2'd0;
      r_hold  <= '0;
      r_to    <= 1'b0;
    end else begin
      if (w_start) begin
        r_owner <= w_gidx;
        r_hold  <= '0;
        r_to    <= 1'b0;
      end else if (r_state == S_ACTIVE) begin
        r_hold  <= r_hold + 1'b1;
        r_to    <= w_own_g && !w_own_d && w_hold_end;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)
      r_err <= 1'b0;
    else if (CLR_STATS)
      r_err <= 1'b0;
    else if (r_state == S_IDLE && w_multi)
      r_err <= 1'b1;
  end

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N)
        r_cnt[i] <= '0;
      else if (CLR_STATS)
        r_cnt[i] <= '0;
      else if (r_state == S_REL && r_owner == 2'(i) && r_cnt[i] != '1)
        r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end

  assign ERR_MULTI = r_err;
  assign GRANT_CNT = r_cnt;

endmodule
